// File: rtl/layer_sequencer_if.sv
// Board- and layer-side signal bundle for layer_sequencer.
// master = sequencer; slave = layer engines plus board control.
interface layer_sequencer_if #(
  parameter int N_LAYERS = 3,
  parameter int OPR_W    = 1024,
  parameter int ROM_AW   = 11
);
  logic                         iStart;
  logic [N_LAYERS-1:0]          layer_done;
  logic [N_LAYERS-1:0]          layer_overflow;
  logic [N_LAYERS*OPR_W-1:0]    layer_opr1;
  logic [N_LAYERS*OPR_W-1:0]    layer_opr2;
  logic [N_LAYERS*ROM_AW-1:0]   layer_rom_addr;
  logic [N_LAYERS-1:0]          layer_ena;
  logic [N_LAYERS-1:0]          layer_rst_n;
  logic [OPR_W-1:0]             opr1_to_MultAdder;
  logic [OPR_W-1:0]             opr2_to_MultAdder;
  logic [ROM_AW-1:0]            addr_to_rom;
  logic [1:0]                   cur_layer;
  logic                         busy;
  logic                         done;
  logic                         overflow;
  logic                         error;

  modport master (
    input  iStart,
    input  layer_done,
    input  layer_overflow,
    input  layer_opr1,
    input  layer_opr2,
    input  layer_rom_addr,
    output layer_ena,
    output layer_rst_n,
    output opr1_to_MultAdder,
    output opr2_to_MultAdder,
    output addr_to_rom,
    output cur_layer,
    output busy,
    output done,
    output overflow,
    output error
  );

  modport slave (
    output iStart,
    output layer_done,
    output layer_overflow,
    output layer_opr1,
    output layer_opr2,
    output layer_rom_addr,
    input  layer_ena,
    input  layer_rst_n,
    input  opr1_to_MultAdder,
    input  opr2_to_MultAdder,
    input  addr_to_rom,
    input  cur_layer,
    input  busy,
    input  done,
    input  overflow,
    input  error
  );
endinterface

// File: rtl/layer_sequencer.sv
// Inference controller: runs layer engines in order, muxes shared MultAdder/ROM.
// Optional per-layer watchdog enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int N_LAYERS       = 3,
  parameter int OPR_W          = 1024,
  parameter int ROM_AW         = 11,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             iRst,
  layer_sequencer_if.master bus
);

  // One counter serves both the reset hold and the run watchdog.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ?
                           TIMEOUT_CYCLES : RST_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(RST_CYCLES - 1);
  localparam logic [1:0] LAST_LAYER = 2'(N_LAYERS - 1);
  localparam logic [N_LAYERS-1:0] ONE = N_LAYERS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          cur_q, cur_d;
  logic [N_LAYERS-1:0] ena_q, ena_d;
  logic [N_LAYERS-1:0] rstn_q, rstn_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [1:0]          nxt;
  logic                lay_done;
  logic                lay_ovf;

  assign nxt      = cur_q + 2'd1;
  assign lay_done = bus.layer_done[cur_q];
  assign lay_ovf  = bus.layer_overflow[cur_q];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ena_d   = ena_q;
    rstn_d  = rstn_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d = S_CLEAR;
          cur_d   = 2'd0;
          ena_d   = ONE;
          rstn_d  = ~ONE;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_RUN;
          rstn_d  = '1;
          cnt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        first_d = 1'b0;
        // A done left over from the previous run is masked on cycle one.
        if (!first_q && lay_done) begin
          ovf_d = ovf_q | lay_ovf;
          if (cur_q == LAST_LAYER) begin
            state_d = S_FINISH;
            ena_d   = '0;
          end else begin
            state_d = S_CLEAR;
            cur_d   = nxt;
            ena_d   = ONE << nxt;
            rstn_d  = ~(ONE << nxt);
            cnt_d   = '0;
          end
`ifdef LAYER_SEQ_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FINISH;
          ena_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        end
`endif
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ena_q   <= '0;
      rstn_q  <= '1;
      cnt_q   <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ena_q   <= ena_d;
      rstn_q  <= rstn_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Unregistered on purpose: layers expect ROM/MultAdder one cycle after issue.
  always_comb begin
    bus.opr1_to_MultAdder = '0;
    bus.opr2_to_MultAdder = '0;
    bus.addr_to_rom       = '0;
    if (|ena_q) begin
      bus.opr1_to_MultAdder = bus.layer_opr1[int'(cur_q)*OPR_W +: OPR_W];
      bus.opr2_to_MultAdder = bus.layer_opr2[int'(cur_q)*OPR_W +: OPR_W];
      bus.addr_to_rom       = bus.layer_rom_addr[int'(cur_q)*ROM_AW +: ROM_AW];
    end
  end

  assign bus.layer_ena   = ena_q;
  assign bus.layer_rst_n = rstn_q;
  assign bus.cur_layer   = cur_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with behavioural layer engines.
// Define LAYER_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_layer_sequencer;
  localparam int N    = 3;
  localparam int W    = 1024;
  localparam int AW   = 11;
  localparam int RSTC = 2;
  localparam int TMO  = 64;
  localparam int HANG = 1 << 30;

  typedef struct packed {
    logic [2:0] ena;
    logic [2:0] rstn;
    logic [1:0] cur;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       err;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  logic clk = 1'b0;
  logic iRst;
  always #5 clk = ~clk;

  layer_sequencer_if #(.N_LAYERS(N), .OPR_W(W), .ROM_AW(AW)) bus ();

  layer_sequencer #(
    .N_LAYERS(N), .OPR_W(W), .ROM_AW(AW),
    .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .iRst(iRst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  ev_t sb[$];

  int lim[3] = '{HANG, HANG, HANG};
  bit ovf_set[3] = '{1'b0, 1'b0, 1'b0};
  bit stale0 = 1'b0;
  int lcnt[3] = '{0, 0, 0};
  logic [W-1:0] p1[3];
  logic [W-1:0] p2[3];
  logic [AW-1:0] pa[3];

  task automatic check(input bit ok, input string nm,
                       input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  function automatic snap_t mk(logic [2:0] ena, logic [2:0] rstn,
                               logic [1:0] cur, logic busy, logic done,
                               logic ovf, logic err);
    snap_t v;
    v.ena = ena; v.rstn = rstn; v.cur = cur;
    v.busy = busy; v.done = done; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  function automatic void push(int c, snap_t v);
    ev_t e;
    e.cyc = c;
    e.s = v;
    sb.push_back(e);
  endfunction

  // Expected visible changes of one run starting at edge s; returns done edge.
  function automatic int push_run(int s, int l[3], bit o[3], bit hang2);
    int t = s;
    bit acc = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [2:0] oh = 3'b001 << k;
      push(t, mk(oh, ~oh, 2'(k), 1, 0, acc, 0));
      push(t + RSTC, mk(oh, 3'b111, 2'(k), 1, 0, acc, 0));
      if (k == N - 1 && hang2) begin
        t = t + RSTC + TMO;
        push(t, mk(3'b000, 3'b111, 2'd2, 1, 0, acc, 1));
        push(t + 1, mk(3'b000, 3'b111, 2'd2, 0, 1, acc, 1));
        return t + 1;
      end
      t = t + RSTC + l[k] + 1;
      acc = acc | o[k];
    end
    push(t, mk(3'b000, 3'b111, 2'd2, 1, 0, acc, 0));
    push(t + 1, mk(3'b000, 3'b111, 2'd2, 0, 1, acc, 0));
    return t + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Layer engines: count enabled cycles out of reset, registered done.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!bus.layer_rst_n[k]) lcnt[k] <= 0;
      else if (bus.layer_ena[k]) lcnt[k] <= lcnt[k] + 1;
    end
  end

  always_comb begin
    bus.layer_done = '0;
    bus.layer_overflow = '0;
    for (int k = 0; k < N; k++) begin
      bus.layer_done[k] = (lcnt[k] >= lim[k]) || (k == 0 && stale0);
      bus.layer_overflow[k] = (lcnt[k] >= lim[k]) && ovf_set[k];
    end
  end

  assign bus.layer_opr1 = {p1[2], p1[1], p1[0]};
  assign bus.layer_opr2 = {p2[2], p2[1], p2[0]};
  assign bus.layer_rom_addr = {pa[2], pa[1], pa[0]};

  snap_t now_s;
  assign now_s = {bus.layer_ena, bus.layer_rst_n, bus.cur_layer,
                  bus.busy, bus.done, bus.overflow, bus.error};

  bit mon_en = 1'b0;
  snap_t last;
  snap_t expv;
  ev_t pe;
  logic [W-1:0] w1, w2;
  logic [AW-1:0] wa;

  always @(negedge clk) begin
    if (mon_en) begin
      if (now_s != last) begin
        if (sb.size() == 0) begin
          check(0, "unexpected_change", 128'(now_s), 128'(last));
        end else begin
          pe = sb.pop_front();
          check(cyc == pe.cyc, "event_cycle", 128'(cyc), 128'(pe.cyc));
          check(now_s == pe.s, "event_state", 128'(now_s), 128'(pe.s));
          expv = pe.s;
        end
        last = now_s;
      end
      check($onehot0(bus.layer_ena), "ena_onehot",
            128'(bus.layer_ena), 128'(expv.ena));
      w1 = '0; w2 = '0; wa = '0;
      if (expv.ena != 3'b000) begin
        w1 = p1[expv.cur]; w2 = p2[expv.cur]; wa = pa[expv.cur];
      end
      check(bus.opr1_to_MultAdder == w1, "mux_opr1",
            bus.opr1_to_MultAdder[127:0], w1[127:0]);
      check(bus.opr2_to_MultAdder == w2, "mux_opr2",
            bus.opr2_to_MultAdder[127:0], w2[127:0]);
      check(bus.addr_to_rom == wa, "mux_addr",
            128'(bus.addr_to_rom), 128'(wa));
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_run(input int l[3], input bit o[3], input bit hang2,
                           output int s, output int e);
    lim = l;
    if (hang2) lim[2] = HANG;
    ovf_set = o;
    bus.iStart = 1'b1;
    s = cyc + 1;
    e = push_run(s, l, o, hang2);
    @(negedge clk);
    bus.iStart = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(sb.size() == 0, "sequence_complete", 128'(sb.size()), 128'(0));
    sb.delete();
  endtask

  function automatic logic [W-1:0] rnd_bus();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles want completion", cyc);
    $fatal(1);
  end

  initial begin
    int l[3];
    bit o[3];
    int s, e, p;
    bus.iStart = 1'b0;
    iRst = 1'b1;
    for (int k = 0; k < N; k++) begin
      p1[k] = {128{8'hA5 + 8'(k)}};
      p2[k] = {128{8'h3C + 8'(k)}};
      pa[k] = AW'(11'h200 + k);
    end
    repeat (3) @(negedge clk);
    check(bus.layer_ena == 3'b000, "rst_ena", 128'(bus.layer_ena), 128'(0));
    check(bus.layer_rst_n == 3'b111, "rst_rstn",
          128'(bus.layer_rst_n), 128'(7));
    check(bus.cur_layer == 2'd0, "rst_cur", 128'(bus.cur_layer), 128'(0));
    check({bus.busy, bus.done, bus.overflow, bus.error} == 4'b0000,
          "rst_flags",
          128'({bus.busy, bus.done, bus.overflow, bus.error}), 128'(0));
    check(bus.opr1_to_MultAdder == '0 && bus.addr_to_rom == '0, "rst_mux",
          bus.opr1_to_MultAdder[127:0], 128'(0));
    last = mk(3'b000, 3'b111, 2'd0, 0, 0, 0, 0);
    expv = last;
    mon_en = 1'b1;
    iRst = 1'b0;
    @(negedge clk);

    // Directed full run 20/15/5.
    l = '{20, 15, 5}; o = '{1'b0, 1'b0, 1'b0};
    start_run(l, o, 1'b0, s, e);
    drain(200);
    check(bus.done && !bus.busy && !bus.overflow, "full_run_end",
          128'({bus.done, bus.busy, bus.overflow}), 128'(3'b100));

    // Overflow from layer 1 only.
    l = '{7, 9, 4}; o = '{1'b0, 1'b1, 1'b0};
    start_run(l, o, 1'b0, s, e);
    drain(200);
    check(bus.overflow == 1'b1, "overflow_sticky", 128'(bus.overflow), 1);

    // iStart pulse during layer 1 RUN is ignored.
    l = '{6, 12, 3}; o = '{1'b0, 1'b0, 1'b0};
    start_run(l, o, 1'b0, s, e);
    wait_to(s + RSTC + l[0] + 1 + RSTC + 2);
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    drain(200);

    // Reset in the middle of layer 1 RUN, then a clean run.
    l = '{5, 20, 4}; o = '{1'b1, 1'b0, 1'b0};
    start_run(l, o, 1'b0, s, e);
    wait_to(s + RSTC + l[0] + 1 + RSTC + 4);
    sb.delete();
    push(cyc + 1, mk(3'b000, 3'b111, 2'd0, 0, 0, 0, 0));
    iRst = 1'b1;
    @(negedge clk);
    iRst = 1'b0;
    drain(20);
    l = '{3, 4, 5}; o = '{1'b0, 1'b0, 1'b1};
    start_run(l, o, 1'b0, s, e);
    drain(200);

    // Stale done on layer 0 across the first RUN cycle.
    l = '{10, 2, 2}; o = '{1'b0, 1'b0, 1'b0};
    stale0 = 1'b1;
    start_run(l, o, 1'b0, s, e);
    wait_to(s + RSTC + 1);
    stale0 = 1'b0;
    drain(200);

    // Randomized runs with stray starts while busy.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < N; k++) begin
        p1[k] = rnd_bus();
        p2[k] = rnd_bus();
        pa[k] = AW'($urandom);
        l[k] = int'($urandom_range(30, 1));
        o[k] = 1'($urandom_range(1, 0));
      end
      repeat ($urandom_range(4, 0)) @(negedge clk);
      start_run(l, o, 1'b0, s, e);
      p = int'($urandom_range(e - 1, s + 1));
      wait_to(p - 1);
      bus.iStart = 1'b1;
      @(negedge clk);
      bus.iStart = 1'b0;
      drain(300);
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    l = '{4, 6, 1}; o = '{1'b0, 1'b1, 1'b0};
    start_run(l, o, 1'b1, s, e);
    drain(300);
    check(bus.error && bus.done && bus.layer_ena == 3'b000, "watchdog_end",
          128'({bus.error, bus.done, bus.layer_ena}), 128'(5'b11000));
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
